// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared symbol codes, token patterns and helpers for Morse key capture
package morse_pkg;

   localparam int BS_W_DEF  = 128;
   localparam int LEN_W_DEF = 9;

   typedef enum logic [1:0] {
      SYM_DIT   = 2'd0,
      SYM_DAH   = 2'd1,
      SYM_CEND  = 2'd2,
      SYM_SPACE = 2'd3
   } sym_code_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS,
      ST_GAP,
      ST_CHAR_GAP
   } cap_state_e;

   localparam logic [0:0] TOK_DIT   = 1'b0;
   localparam logic [1:0] TOK_DAH   = 2'b10;
   localparam logic [1:0] TOK_CEND  = 2'b11;
   localparam logic [3:0] TOK_SPACE = 4'b1111;

   // number of bitstream bits a token occupies
   function automatic logic [2:0] tok_len(input sym_code_e code);
      case (code)
         SYM_DIT:  return 3'd1;
         SYM_DAH:  return 3'd2;
         SYM_CEND: return 3'd2;
         default:  return 3'd4;
      endcase
   endfunction

   // token pattern left-aligned in a 4-bit field, unused low bits zero
   function automatic logic [3:0] tok_bits_left(input sym_code_e code);
      case (code)
         SYM_DIT:  return {TOK_DIT, 3'b000};
         SYM_DAH:  return {TOK_DAH, 2'b00};
         SYM_CEND: return {TOK_CEND, 2'b00};
         default:  return TOK_SPACE;
      endcase
   endfunction

   // increment that sticks at all-ones
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/morse_bit_packer.sv
// rtl/morse_bit_packer.sv - packs symbol tokens MSB-first into the frame buffer and publishes it
module morse_bit_packer
   import morse_pkg::*;
#(
   parameter int BS_W  = BS_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             append,
   input  sym_code_e        append_code,
   input  logic             publish,
   input  logic             clear,
   output logic             sym_valid,
   output logic [1:0]       sym_code,
   output logic             frame_valid,
   output logic [BS_W-1:0]  frame_bitstream,
   output logic [LEN_W-1:0] frame_length,
   output logic             overflow
);

   logic [BS_W-1:0]  buf_q;
   logic [LEN_W-1:0] len_q;

   logic [LEN_W:0]   len_sum;
   logic             fits;
   logic [BS_W-1:0]  tok_word;
   logic [BS_W-1:0]  buf_a;
   logic [LEN_W-1:0] len_a;
   logic             ovf_a;
   logic             appended;

   // buffer contents after this cycle's optional append; the low bits past len are always zero so OR suffices
   always_comb begin
      len_sum  = {1'b0, len_q} + (LEN_W+1)'(tok_len(append_code));
      fits     = (len_sum <= (LEN_W+1)'(BS_W));
      tok_word = {tok_bits_left(append_code), {(BS_W-4){1'b0}}} >> len_q;
      buf_a    = buf_q;
      len_a    = len_q;
      ovf_a    = overflow;
      appended = 1'b0;
      if (append) begin
         if (fits) begin
            buf_a    = buf_q | tok_word;
            len_a    = len_sum[LEN_W-1:0];
            appended = 1'b1;
         end else begin
            ovf_a = 1'b1;
         end
      end
   end

   // buffer state, token strobe and frame publication
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_q           <= '0;
         len_q           <= '0;
         overflow        <= 1'b0;
         sym_valid       <= 1'b0;
         sym_code        <= 2'd0;
         frame_valid     <= 1'b0;
         frame_bitstream <= '0;
         frame_length    <= '0;
      end else begin
         sym_valid   <= appended && !clear;
         frame_valid <= 1'b0;
         if (appended && !clear) begin
            sym_code <= append_code;
         end
         if (clear) begin
            buf_q    <= '0;
            len_q    <= '0;
            overflow <= 1'b0;
         end else if (publish) begin
            if (len_a != '0) begin
               frame_valid     <= 1'b1;
               frame_bitstream <= buf_a;
               frame_length    <= len_a;
            end
            buf_q    <= '0;
            len_q    <= '0;
            overflow <= 1'b0;
         end else begin
            buf_q    <= buf_a;
            len_q    <= len_a;
            overflow <= ovf_a;
         end
      end
   end

endmodule

// File: rtl/morse_key_bitstream_capture.sv
// rtl/morse_key_bitstream_capture.sv - key press/gap timing FSM feeding the Morse bit packer
module morse_key_bitstream_capture
   import morse_pkg::*;
#(
   parameter int BS_W  = BS_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             capture_en,
   input  logic             key_level,
   input  logic [31:0]      long_key_cycles,
   input  logic [31:0]      timeout_cycles,
   input  logic [31:0]      space_cycles,
   input  logic             commit,
   input  logic             clear,
   output logic             sym_valid,
   output logic [1:0]       sym_code,
   output logic             frame_valid,
   output logic [BS_W-1:0]  frame_bitstream,
   output logic [LEN_W-1:0] frame_length,
   output logic             overflow
);

   cap_state_e  state;
   logic [31:0] press_cnt;
   logic [31:0] gap_cnt;
   logic [31:0] press_inc;
   logic [31:0] gap_inc;
   logic        dah_hit;
   logic        cend_hit;
   logic        space_hit;
   logic        tok_valid;
   sym_code_e   tok_code;
   logic        do_publish;
   logic        do_clear;
   logic        force_idle;

   // token and buffer-command decode; clear beats commit, and commit absorbs any threshold hit this cycle
   always_comb begin
      press_inc  = sat_inc(press_cnt);
      gap_inc    = sat_inc(gap_cnt);
      dah_hit    = (press_cnt >= long_key_cycles);
      cend_hit   = (gap_inc >= timeout_cycles);
      space_hit  = (gap_inc >= space_cycles);
      tok_valid  = 1'b0;
      tok_code   = SYM_DIT;
      do_publish = 1'b0;
      do_clear   = 1'b0;
      if (capture_en) begin
         if (clear) begin
            do_clear = 1'b1;
         end else if (commit && state != ST_PRESS) begin
            do_publish = 1'b1;
            if (state == ST_GAP) begin
               tok_valid = 1'b1;
               tok_code  = SYM_CEND;
            end
         end else begin
            case (state)
               ST_PRESS: begin
                  if (!key_level) begin
                     tok_valid = 1'b1;
                     tok_code  = dah_hit ? SYM_DAH : SYM_DIT;
                  end
               end
               ST_GAP: begin
                  if (!key_level && cend_hit) begin
                     tok_valid = 1'b1;
                     tok_code  = SYM_CEND;
                  end
               end
               ST_CHAR_GAP: begin
                  if (!key_level && space_hit) begin
                     tok_valid = 1'b1;
                     tok_code  = SYM_SPACE;
                  end
               end
               default: ;
            endcase
         end
      end
      force_idle = !capture_en || do_clear || do_publish;
   end

   // key timing FSM with saturating press and gap counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         press_cnt <= '0;
         gap_cnt   <= '0;
      end else if (force_idle) begin
         state     <= ST_IDLE;
         press_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (key_level) begin
                  state     <= ST_PRESS;
                  press_cnt <= 32'd1;
               end
            end
            ST_PRESS: begin
               if (key_level) begin
                  press_cnt <= press_inc;
               end else begin
                  state   <= ST_GAP;
                  gap_cnt <= 32'd1;
               end
            end
            ST_GAP: begin
               if (key_level) begin
                  state     <= ST_PRESS;
                  press_cnt <= 32'd1;
               end else begin
                  gap_cnt <= gap_inc;
                  if (cend_hit) begin
                     state <= ST_CHAR_GAP;
                  end
               end
            end
            ST_CHAR_GAP: begin
               if (key_level) begin
                  state     <= ST_PRESS;
                  press_cnt <= 32'd1;
               end else begin
                  gap_cnt <= gap_inc;
                  if (space_hit) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   morse_bit_packer #(
      .BS_W  (BS_W),
      .LEN_W (LEN_W)
   ) u_packer (
      .clk             (clk),
      .rst_n           (rst_n),
      .append          (tok_valid),
      .append_code     (tok_code),
      .publish         (do_publish),
      .clear           (do_clear),
      .sym_valid       (sym_valid),
      .sym_code        (sym_code),
      .frame_valid     (frame_valid),
      .frame_bitstream (frame_bitstream),
      .frame_length    (frame_length),
      .overflow        (overflow)
   );

endmodule
